// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants and types for the UART receive path and its byte FIFO.
package uart_rx_fifo_pkg;

    localparam int unsigned CLK_HZ_DEF     = 32'd100_000_000;
    localparam int unsigned BAUD_DEF       = 32'd9600;
    localparam int unsigned OVERSAMPLE     = 32'd16;
    localparam int unsigned FIFO_DEPTH_DEF = 32'd16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: synchronizer, tick generator and framing FSM.
module uart_rx
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned CLK_HZ = CLK_HZ_DEF,
    parameter int unsigned BAUD   = BAUD_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err
);

    localparam int unsigned     DIV      = baud_div(CLK_HZ, BAUD);
    localparam int              DIV_W    = (DIV > 32'd1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 32'd1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_rx_prev;
    logic [DIV_W-1:0] r_div_cnt;
    logic [3:0]       r_tick_cnt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    rx_state_e        r_state;

    rx_state_e        w_state_nxt;
    logic             w_tick;
    logic             w_fall;
    logic             w_sample;
    logic             w_done;
    logic             w_ferr;

    assign w_tick = (r_div_cnt == DIV_LAST);
    assign w_fall = r_rx_prev & ~r_sync2;

    // Two-flop synchronizer plus one delay stage for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= rx;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    // Baud tick divider and per-state tick counter; both restart at every state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt  <= '0;
            r_tick_cnt <= 4'd0;
        end else begin
            if ((r_state != w_state_nxt) || w_tick) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
            if (r_state != w_state_nxt) begin
                r_tick_cnt <= 4'd0;
            end else if (w_tick) begin
                r_tick_cnt <= r_tick_cnt + 4'd1;
            end
        end
    end

    // Framing state, bit counter and LSB-first shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_START) begin
                r_bit_cnt <= 3'd0;
            end else if (w_sample) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_sample) begin
                r_shift <= {r_sync2, r_shift[7:1]};
            end
        end
    end

    // Next state; START checks mid start bit, DATA/STOP sample mid bit.
    always_comb begin
        w_state_nxt = r_state;
        w_sample    = 1'b0;
        w_done      = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fall) w_state_nxt = ST_START;
                else        w_state_nxt = ST_IDLE;
            end
            ST_START: begin
                if (w_tick && (r_tick_cnt == 4'd7)) begin
                    w_state_nxt = r_sync2 ? ST_IDLE : ST_DATA;
                end else begin
                    w_state_nxt = ST_START;
                end
            end
            ST_DATA: begin
                if (w_tick && (r_tick_cnt == 4'd15)) begin
                    w_sample    = 1'b1;
                    w_state_nxt = (r_bit_cnt == 3'd7) ? ST_STOP : ST_DATA;
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_STOP: begin
                if (w_tick && (r_tick_cnt == 4'd15)) begin
                    w_state_nxt = ST_IDLE;
                    w_done      = r_sync2;
                    w_ferr      = ~r_sync2;
                end else begin
                    w_state_nxt = ST_STOP;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign rx_data   = r_shift;
    assign rx_done   = w_done;
    assign frame_err = w_ferr;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver feeding a show-ahead byte FIFO with sticky overflow.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned CLK_HZ     = CLK_HZ_DEF,
    parameter int unsigned BAUD       = BAUD_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       pop,
    output logic [7:0] fifo_data,
    output logic       rx_empty,
    output logic       rx_full,
    output logic       overflow,
    output logic       frame_err
);

    localparam int               PTR_W    = $clog2(FIFO_DEPTH);
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    logic [7:0]       w_rx_data;
    logic             w_rx_done;
    logic             w_pop_ok;
    logic             w_push_ok;
    logic             w_drop;

    uart_rx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (w_rx_data),
        .rx_done   (w_rx_done),
        .frame_err (frame_err)
    );

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
    assign w_pop_ok  = pop & (r_count != '0);
    assign w_push_ok = w_rx_done & ((r_count != CNT_FULL) | w_pop_ok);
    assign w_drop    = w_rx_done & ~w_push_ok;

    // Pointer, occupancy and sticky overflow bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    // Byte storage.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= w_rx_data;
    end

    assign fifo_data = r_mem[r_rd_ptr];
    assign rx_empty  = (r_count == '0);
    assign rx_full   = (r_count == CNT_FULL);
    assign overflow  = r_overflow;

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL use one clock and a reset that is synchronous and active-high, with ports named clk and rst.
REQ-002 Parameter CLK_HZ SHALL default to 100_000_000 and give the clk frequency in Hz.
REQ-003 Parameter BAUD SHALL default to 9600 and give the serial bit rate.
REQ-004 Parameter FIFO_DEPTH SHALL default to 16; it is a power of 2, minimum 2.
REQ-005 Port clk SHALL be an input, 1 bit: system clock.
REQ-006 Port rst SHALL be an input, 1 bit: synchronous active-high reset.
REQ-007 Port rx SHALL be an input, 1 bit: asynchronous UART serial line, idle high.
REQ-008 Port pop SHALL be an input, 1 bit: read strobe from the command decoder, one byte per asserted cycle.
REQ-009 Port fifo_data SHALL be an output, 8 bits: oldest stored byte, show-ahead.
REQ-010 Port rx_empty SHALL be an output, 1 bit: high when the FIFO holds no bytes; it connects to the decoder's rx_trigger.
REQ-011 Port rx_full SHALL be an output, 1 bit: high when the FIFO holds FIFO_DEPTH bytes.
REQ-012 Port overflow SHALL be an output, 1 bit: sticky flag, set when a received byte is dropped.
REQ-013 Port frame_err SHALL be an output, 1 bit: one-cycle pulse on a bad stop bit.

Function
REQ-014 rx SHALL pass through a 2-flop synchronizer before any use.
REQ-015 A tick generator SHALL pulse one clk cycle every DIV = CLK_HZ/(BAUD*16) cycles, integer-truncated (651 at the defaults).
REQ-016 The receiver FSM SHALL have states IDLE, START, DATA and STOP.
REQ-017 IDLE->START SHALL occur on a synchronized falling edge of rx, and the tick-phase counter SHALL clear on that transition.
REQ-018 In START, after 8 ticks, rx low SHALL go to DATA and rx high SHALL return to IDLE (glitch rejection, no push).
REQ-019 In DATA, rx SHALL be sampled every 16 ticks into the shift register LSB first, and the FSM SHALL go to STOP after 8 bits.
REQ-020 In STOP, after 16 ticks, rx high SHALL push the byte and return to IDLE.
REQ-021 In STOP, after 16 ticks, rx low SHALL pulse frame_err for 1 cycle, discard the byte and return to IDLE.
REQ-022 A push SHALL occur in the cycle of the stop-bit sample, and rx_empty SHALL fall on the following clk edge.
REQ-023 fifo_data SHALL equal mem[rd_ptr] combinationally, so it is valid whenever rx_empty=0.
REQ-024 A pop with rx_empty=0 SHALL advance rd_ptr on that clk edge.
REQ-025 A pop with rx_empty=1 SHALL be ignored, with no pointer, count or flag change.
REQ-026 A push with rx_full=1 and no pop SHALL drop the byte and set overflow.
REQ-027 A push and pop in the same cycle with rx_full=1 SHALL both take effect, with count unchanged and no overflow.
REQ-028 A push and pop in the same cycle with rx_empty=1 SHALL accept the push and ignore the pop.
REQ-029 Pointers SHALL be log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
REQ-030 The occupancy count SHALL be log2(FIFO_DEPTH)+1 bits, with rx_empty = (count==0) and rx_full = (count==FIFO_DEPTH).
REQ-031 overflow SHALL be cleared only by rst.

Reset
REQ-032 rst SHALL set the FSM to IDLE and clear the tick counter, bit counter, shift register and pointers.
REQ-033 rst SHALL set count=0, rx_empty=1, rx_full=0, overflow=0, frame_err=0 and both synchronizer flops to 1.
REQ-034 rst asserted mid-frame SHALL abandon the frame with no push; reception SHALL restart on the next falling edge after rst deasserts.

Structure
REQ-035 CLK_HZ, BAUD, oversample factor 16 and FIFO_DEPTH defaults SHALL live in the shared project constants include.
REQ-036 Serial reception (synchronizer, tick generator, FSM) SHALL be a sub-module uart_rx with outputs rx_data[7:0], rx_done and frame_err.
REQ-037 The FIFO storage and pointers SHALL live in uart_rx_fifo itself.

Verification
REQ-038 Send 'm' (0x6D) at 9600 baud -> rx_empty falls about 9.5 bit times after the start edge with fifo_data=0x6D; pop 1 cycle -> rx_empty=1.
REQ-039 Send 17 bytes 0x00..0x10 with no pop -> rx_full=1 after byte 16, overflow=1 after byte 17; 16 pops return 0x00..0x0F in order, then rx_empty=1.
REQ-040 Drive an rx low glitch of 3 ticks -> no push, FSM back in IDLE, rx_empty stays 1.
REQ-041 Send 0x41 with the stop bit held low -> one-cycle frame_err pulse, no push.
REQ-042 Assert rst during the DATA bit 4 of 0x55, then send 0x2B -> only 0x2B is stored.
REQ-043 Pop while empty, and push+pop while full in the same cycle -> count unchanged, no overflow, FIFO order preserved.
